// File: rtl/io_periph_dev.sv
// Host-side I/O peripheral: strobe synchronizers, write FSM with busy timer,
// 4-entry show-ahead output FIFO and a one-byte input register for host reads.
//
// state | meaning
// IDLE  | ready for a host write (SIPn low unless the FIFO is full)
// BUSY  | write accepted, busy_cnt counting down to 0
module io_periph_dev #(
  parameter logic [7:0] DEV_ADDR    = 8'hC0,
  parameter int         BUSY_CYCLES = 16
) (
  input  logic       io_clk,
  input  logic       init,
  input  logic [3:0] Y3n,
  input  logic [3:0] X3n,
  input  logic [3:0] Y2n,
  input  logic [3:0] X2n,
  input  logic       out_stb_n,
  input  logic       rd_stb_n,
  output logic [7:0] dev_out_data,
  output logic       dev_out_valid,
  input  logic       dev_out_ready,
  input  logic [7:0] dev_in_data,
  input  logic       dev_in_valid,
  output logic       dev_in_ready,
  output logic [3:0] VVb,
  output logic [3:0] VVa,
  output logic       SIPn,
  output logic       SIP_Vn,
  output logic       overrun
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  logic [1:0] r_wr_sync;
  logic       r_wr_dly;
  logic [1:0] r_rd_sync;
  logic       r_rd_dly;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_busy_cnt;
  logic [7:0] w_busy_cnt_nxt;

  logic [7:0] r_mem [4];
  logic [1:0] r_wptr;
  logic [1:0] r_rptr;
  logic [2:0] r_count;

  logic [7:0] r_in_data;
  logic       r_in_full;
  logic       r_overrun;

  logic w_wr_ev;
  logic w_rd_ev;
  logic w_addr_hit;
  logic w_wr_hit;
  logic w_rd_hit;
  logic w_full;
  logic w_push;
  logic w_drop;
  logic w_pop;
  logic w_in_load;

  // Strobes are async to io_clk; the delay flop turns the synced level into a falling-edge pulse.
  always_ff @(posedge io_clk or posedge init) begin
    if (init) begin
      r_wr_sync <= 2'b11;
      r_wr_dly  <= 1'b1;
      r_rd_sync <= 2'b11;
      r_rd_dly  <= 1'b1;
    end else begin
      r_wr_sync <= {r_wr_sync[0], out_stb_n};
      r_wr_dly  <= r_wr_sync[1];
      r_rd_sync <= {r_rd_sync[0], rd_stb_n};
      r_rd_dly  <= r_rd_sync[1];
    end
  end

  assign w_wr_ev    = r_wr_dly & ~r_wr_sync[1];
  assign w_rd_ev    = r_rd_dly & ~r_rd_sync[1];
  assign w_addr_hit = (~{Y3n, X3n}) == DEV_ADDR;
  assign w_wr_hit   = w_wr_ev & w_addr_hit;
  assign w_rd_hit   = w_rd_ev & w_addr_hit;

  // Fullness is taken before any same-cycle pop, so a write to a full FIFO is always dropped.
  assign w_full = (r_count == 3'd4);
  assign w_push = w_wr_hit & (r_state == IDLE) & ~w_full;
  assign w_drop = w_wr_hit & ((r_state == BUSY) | w_full);
  assign w_pop  = (r_count != 3'd0) & dev_out_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_busy_cnt_nxt = r_busy_cnt;
    case (r_state)
      IDLE: begin
        if (w_push) begin
          w_state_nxt    = BUSY;
          w_busy_cnt_nxt = 8'(BUSY_CYCLES - 1);
        end
      end
      BUSY: begin
        if (r_busy_cnt == 8'd0) begin
          w_state_nxt = IDLE;
        end else begin
          w_busy_cnt_nxt = r_busy_cnt - 8'd1;
        end
      end
      default: begin
        w_state_nxt    = IDLE;
        w_busy_cnt_nxt = 8'd0;
      end
    endcase
  end

  always_ff @(posedge io_clk or posedge init) begin
    if (init) begin
      r_state    <= IDLE;
      r_busy_cnt <= 8'd0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_busy_cnt <= w_busy_cnt_nxt;
      if (w_drop) r_overrun <= 1'b1;
    end
  end

  always_ff @(posedge io_clk or posedge init) begin
    if (init) begin
      for (int i = 0; i < 4; i++) r_mem[i] <= 8'h00;
      r_wptr  <= 2'd0;
      r_rptr  <= 2'd0;
      r_count <= 3'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= ~{Y2n, X2n};
        r_wptr        <= r_wptr + 2'd1;
      end
      if (w_pop) r_rptr <= r_rptr + 2'd1;
      r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
    end
  end

  // A device load takes priority over a host read clearing the register.
  assign w_in_load = dev_in_valid & ~r_in_full;

  always_ff @(posedge io_clk or posedge init) begin
    if (init) begin
      r_in_data <= 8'h00;
      r_in_full <= 1'b0;
    end else if (w_in_load) begin
      r_in_data <= dev_in_data;
      r_in_full <= 1'b1;
    end else if (w_rd_hit & r_in_full) begin
      r_in_data <= 8'h00;
      r_in_full <= 1'b0;
    end
  end

  assign dev_out_data  = r_mem[r_rptr];
  assign dev_out_valid = (r_count != 3'd0);
  assign dev_in_ready  = ~r_in_full;
  assign {VVb, VVa}    = r_in_full ? r_in_data : 8'h00;
  assign SIPn          = ~((r_state == IDLE) & ~w_full);
  assign SIP_Vn        = ~r_in_full;
  assign overrun       = r_overrun;

endmodule

// File: tb/tb_io_periph_dev.sv
// Self-checking bench for io_periph_dev: scoreboard on the output FIFO plus
// direct checks of SIPn timing, overrun, input register and async reset.
module tb_io_periph_dev;

  logic       io_clk = 1'b0;
  logic       init   = 1'b1;
  logic [3:0] Y3n = 4'hF, X3n = 4'hF, Y2n = 4'hF, X2n = 4'hF;
  logic       out_stb_n = 1'b1, rd_stb_n = 1'b1;
  logic       dev_out_ready = 1'b0;
  logic [7:0] dev_in_data = 8'h00;
  logic       dev_in_valid = 1'b0;

  // instance a: default BUSY_CYCLES=16, instance b: BUSY_CYCLES=1
  logic [7:0] dout_a, dout_b;
  logic       dval_a, dval_b, dinr_a, dinr_b, sipn_a, sipn_b;
  logic       sipvn_a, sipvn_b, ovr_a, ovr_b;
  logic [3:0] vvb_a, vva_a, vvb_b, vva_b;

  io_periph_dev u_dut_a (
    .io_clk(io_clk), .init(init), .Y3n(Y3n), .X3n(X3n), .Y2n(Y2n), .X2n(X2n),
    .out_stb_n(out_stb_n), .rd_stb_n(rd_stb_n),
    .dev_out_data(dout_a), .dev_out_valid(dval_a), .dev_out_ready(dev_out_ready),
    .dev_in_data(dev_in_data), .dev_in_valid(dev_in_valid), .dev_in_ready(dinr_a),
    .VVb(vvb_a), .VVa(vva_a), .SIPn(sipn_a), .SIP_Vn(sipvn_a), .overrun(ovr_a)
  );

  io_periph_dev #(.DEV_ADDR(8'hC0), .BUSY_CYCLES(1)) u_dut_b (
    .io_clk(io_clk), .init(init), .Y3n(Y3n), .X3n(X3n), .Y2n(Y2n), .X2n(X2n),
    .out_stb_n(out_stb_n), .rd_stb_n(rd_stb_n),
    .dev_out_data(dout_b), .dev_out_valid(dval_b), .dev_out_ready(dev_out_ready),
    .dev_in_data(dev_in_data), .dev_in_valid(dev_in_valid), .dev_in_ready(dinr_b),
    .VVb(vvb_b), .VVa(vva_b), .SIPn(sipn_b), .SIP_Vn(sipvn_b), .overrun(ovr_b)
  );

  always #5 io_clk = ~io_clk;

  int         n_total = 0;
  int         n_bad   = 0;
  logic [7:0] sb_q[$];
  bit         sel_b = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Pops are sampled mid-cycle; the pop itself happens at the next rising edge.
  always @(negedge io_clk) begin
    if (!init) begin
      if (!sel_b && dval_a && dev_out_ready) begin
        if (sb_q.size() == 0) chk("sb_unexp_a", {24'h0, dout_a}, 32'hFFFF_FFFF);
        else chk("sb_data_a", {24'h0, dout_a}, {24'h0, sb_q.pop_front()});
      end
      if (sel_b && dval_b && dev_out_ready) begin
        if (sb_q.size() == 0) chk("sb_unexp_b", {24'h0, dout_b}, 32'hFFFF_FFFF);
        else chk("sb_data_b", {24'h0, dout_b}, {24'h0, sb_q.pop_front()});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge io_clk);
    #1;
  endtask

  task automatic set_bus(input logic [7:0] a, input logic [7:0] d);
    Y3n = ~a[7:4]; X3n = ~a[3:0]; Y2n = ~d[7:4]; X2n = ~d[3:0];
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    set_bus(a, d);
    out_stb_n = 1'b0;
    cyc(4);
    out_stb_n = 1'b1;
    cyc(3);
  endtask

  task automatic rd(input logic [7:0] a);
    set_bus(a, 8'h00);
    rd_stb_n = 1'b0;
    cyc(4);
    rd_stb_n = 1'b1;
    cyc(3);
  endtask

  task automatic do_reset();
    init = 1'b1;
    #1;
    chk("rst_dval", {31'h0, dval_a}, 32'd0);
    chk("rst_sipn", {31'h0, sipn_a}, 32'd0);
    chk("rst_ovr", {31'h0, ovr_a}, 32'd0);
    chk("rst_sipvn", {31'h0, sipvn_a}, 32'd1);
    chk("rst_dinr", {31'h0, dinr_a}, 32'd1);
    chk("rst_vv", {24'h0, vvb_a, vva_a}, 32'd0);
    sb_q.delete();
    cyc(2);
    init = 1'b0;
    cyc(2);
  endtask

  initial begin
    int n;
    cyc(1);
    do_reset();

    // single write, SIPn busy window
    sel_b = 1'b0;
    dev_out_ready = 1'b0;
    set_bus(8'hC0, 8'h5A);
    chk("bus_enc", {16'h0, Y3n, X3n, Y2n, X2n}, 32'h3FA5);
    sb_q.push_back(8'h5A);
    out_stb_n = 1'b0;
    cyc(2);
    chk("wr_not_yet", {31'h0, dval_a}, 32'd0);
    cyc(1);
    chk("wr_valid", {31'h0, dval_a}, 32'd1);
    chk("wr_head", {24'h0, dout_a}, 32'h5A);
    out_stb_n = 1'b1;
    n = 0;
    while (sipn_a && n < 40) begin
      n++;
      cyc(1);
    end
    chk("busy_len", n, 32'd16);
    chk("sipn_idle", {31'h0, sipn_a}, 32'd0);
    dev_out_ready = 1'b1;
    cyc(3);
    chk("drain1_q", sb_q.size(), 32'd0);
    chk("drain1_dval", {31'h0, dval_a}, 32'd0);

    // wrong address
    wr(8'hD0, 8'h99);
    cyc(1);
    chk("badaddr_dval", {31'h0, dval_a}, 32'd0);
    chk("badaddr_sipn", {31'h0, sipn_a}, 32'd0);
    chk("badaddr_ovr", {31'h0, ovr_a}, 32'd0);

    // write during BUSY is dropped
    do_reset();
    dev_out_ready = 1'b0;
    sb_q.push_back(8'h11);
    wr(8'hC0, 8'h11);
    wr(8'hC0, 8'h22);
    chk("busydrop_ovr", {31'h0, ovr_a}, 32'd1);
    chk("busydrop_sipn", {31'h0, sipn_a}, 32'd1);
    dev_out_ready = 1'b1;
    cyc(3);
    chk("busydrop_q", sb_q.size(), 32'd0);
    chk("busydrop_dval", {31'h0, dval_a}, 32'd0);

    // FIFO full overrun on the BUSY_CYCLES=1 instance
    do_reset();
    sel_b = 1'b1;
    dev_out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) sb_q.push_back(8'(i));
      wr(8'hC0, 8'(i));
      if (i == 1) chk("b_idle_after1", {31'h0, sipn_b}, 32'd0);
    end
    chk("full_ovr", {31'h0, ovr_b}, 32'd1);
    chk("full_sipn", {31'h0, sipn_b}, 32'd1);
    chk("full_head", {24'h0, dout_b}, 32'h01);
    dev_out_ready = 1'b1;
    cyc(6);
    chk("full_q", sb_q.size(), 32'd0);
    chk("full_dval", {31'h0, dval_b}, 32'd0);
    chk("full_sipn_after", {31'h0, sipn_b}, 32'd0);
    chk("full_ovr_sticky", {31'h0, ovr_b}, 32'd1);
    sel_b = 1'b0;

    // input register
    do_reset();
    dev_in_data = 8'h3C;
    dev_in_valid = 1'b1;
    cyc(1);
    dev_in_valid = 1'b0;
    chk("in_vv", {24'h0, vvb_a, vva_a}, 32'h3C);
    chk("in_sipvn", {31'h0, sipvn_a}, 32'd0);
    chk("in_rdy", {31'h0, dinr_a}, 32'd0);
    rd(8'hD0);
    chk("rd_badaddr", {31'h0, sipvn_a}, 32'd0);
    rd(8'hC0);
    chk("rd_sipvn", {31'h0, sipvn_a}, 32'd1);
    chk("rd_vv", {24'h0, vvb_a, vva_a}, 32'h00);
    chk("rd_rdy", {31'h0, dinr_a}, 32'd1);
    dev_in_data = 8'h55;
    dev_in_valid = 1'b1;
    cyc(1);
    dev_in_data = 8'h77;
    rd(8'hC0);
    dev_in_valid = 1'b0;
    chk("rdload_vv", {24'h0, vvb_a, vva_a}, 32'h77);
    chk("rdload_sipvn", {31'h0, sipvn_a}, 32'd0);

    // reset in the middle of BUSY with 3 queued bytes
    do_reset();
    dev_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr(8'hC0, 8'hA0 + 8'(i));
      if (i < 2) cyc(12);
    end
    wr(8'hC0, 8'hEE);
    chk("mid_dval", {31'h0, dval_a}, 32'd1);
    chk("mid_head", {24'h0, dout_a}, 32'hA0);
    chk("mid_ovr", {31'h0, ovr_a}, 32'd1);
    chk("mid_sipn", {31'h0, sipn_a}, 32'd1);
    do_reset();
    chk("post_dval", {31'h0, dval_a}, 32'd0);
    chk("post_sipn", {31'h0, sipn_a}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
